// File: rtl/cc_deserializer.sv
// Collects an 8-beat critical-word-first read burst into a 512-bit line and pushes
// {offset, line} into the line-fill FIFO. Define CC_DESERIALIZER_RLAST_CHECK_EN to flag rlast framing errors.
module cc_deserializer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_i,
  input  logic [5:0]   req_offset_i,
  output logic         req_ready_o,
  input  logic [63:0]  mem_rdata_i,
  input  logic         mem_rlast_i,
  input  logic         mem_rvalid_i,
  output logic         mem_rready_o,
  input  logic         fifo_full_i,
  output logic         fifo_wren_o,
  output logic [517:0] fifo_wdata_o,
  output logic         error_o
);
  localparam int NUM_WORDS = 8;
  localparam int WORD_W    = 64;

  typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_e;

  state_e                              state_q, state_d;
  logic [2:0]                          cnt_q, cnt_d;
  logic [5:0]                          off_q, off_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    word_q;
  logic                                beat_hs;
  logic [2:0]                          wr_idx;

  assign beat_hs = mem_rvalid_i & mem_rready_o;
  // 3-bit add wraps the burst around the line starting at the critical word
  assign wr_idx  = off_q[5:3] + cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    req_ready_o  = 1'b0;
    mem_rready_o = 1'b0;
    fifo_wren_o  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          off_d   = req_offset_i;
          cnt_d   = 3'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PUSH;
        end
      end
      PUSH: begin
        fifo_wren_o = ~fifo_full_i;
        if (!fifo_full_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      off_q   <= 6'd0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      if (beat_hs) word_q[wr_idx] <= mem_rdata_i;
    end
  end

  assign fifo_wdata_o = {off_q, word_q};

`ifdef CC_DESERIALIZER_RLAST_CHECK_EN
  logic err_q;
  // rlast must coincide exactly with the 8th beat
  always_ff @(posedge clk) begin
    if (!rst_n)                                          err_q <= 1'b0;
    else if (beat_hs && (mem_rlast_i != (cnt_q == 3'd7))) err_q <= 1'b1;
  end
  assign error_o = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = mem_rlast_i;
  assign error_o      = 1'b0;
`endif
endmodule
